// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store alignment unit: word-aligned memory accesses, misaligned split, load extension
module lsu_align #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  dm_re,
  output logic                  dm_we,
  output logic [DM_ADDRESS-1:0] dm_addr,
  output logic [3:0]            dm_be,
  output logic [DATA_W-1:0]     dm_wd,
  input  logic [DATA_W-1:0]     dm_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     lo_q;

  logic [1:0]            off;
  logic [1:0]            size;
  logic [3:0]            mask;
  logic                  split;
  logic                  sign_ld;
  logic [2:0]            rshift;
  logic [DM_ADDRESS-1:0] word0;
  logic [DM_ADDRESS-1:0] word1;
  logic [3:0]            be0;
  logic [3:0]            be1;
  logic [DATA_W-1:0]     wd0;
  logic [DATA_W-1:0]     wd1;
  logic [2*DATA_W-1:0]   pair;
  logic [2*DATA_W-1:0]   pair_sh;
  logic [DATA_W-1:0]     raw;
  logic [DATA_W-1:0]     ext;

  // Access size: 0 byte, 1 half, 2 word; unrecognised encodings fall back to word.
  always_comb begin
    size    = 2'd2;
    sign_ld = 1'b0;
    case (funct3_q)
      3'b000: begin size = 2'd0; sign_ld = 1'b1; end
      3'b001: begin size = 2'd1; sign_ld = 1'b1; end
      3'b100: size = 2'd0;
      3'b101: size = 2'd1;
      default: size = 2'd2;
    endcase
  end

  always_comb begin
    off = addr_q[1:0];
    case (size)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    split  = ((size == 2'd1) && (off == 2'd3)) || ((size == 2'd2) && (off != 2'd0));
    rshift = 3'd4 - {1'b0, off};
    word0  = {addr_q[DM_ADDRESS-1:2], 2'b00};
    word1  = word0 + DM_ADDRESS'(4);
    be0    = mask << off;
    be1    = mask >> rshift;
    wd0    = wdata_q << {off, 3'b000};
    wd1    = wdata_q >> {rshift, 3'b000};
  end

  // Non-split loads see only the single word in the low half of the pair.
  always_comb begin
    pair    = split ? {dm_rdata, lo_q} : {{DATA_W{1'b0}}, dm_rdata};
    pair_sh = pair >> {off, 3'b000};
    raw     = pair_sh[DATA_W-1:0];
    case (size)
      2'd0:    ext = sign_ld ? {{(DATA_W-8){raw[7]}}, raw[7:0]}
                             : {{(DATA_W-8){1'b0}}, raw[7:0]};
      2'd1:    ext = sign_ld ? {{(DATA_W-16){raw[15]}}, raw[15:0]}
                             : {{(DATA_W-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ACC0;
      ACC0:    state_nxt = split ? ACC1 : DONE;
      ACC1:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      lo_q     <= '0;
    end else begin
      if ((state == IDLE) && req_valid) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      // Data for the ACC0 read arrives during ACC1.
      if (state == ACC1) begin
        lo_q <= dm_rdata;
      end
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    dm_re      = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = '0;
    dm_be      = 4'b0000;
    dm_wd      = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      ACC0: begin
        dm_re   = !we_q;
        dm_we   = we_q;
        dm_addr = word0;
        if (we_q) begin
          dm_be = be0;
          dm_wd = wd0;
        end
      end
      ACC1: begin
        dm_re   = !we_q;
        dm_we   = we_q;
        dm_addr = word1;
        if (we_q) begin
          dm_be = be1;
          dm_wd = wd1;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? '0 : ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - scoreboard bench for lsu_align with a byte-lane memory model
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        dm_re;
  logic        dm_we;
  logic [8:0]  dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wd;
  logic [31:0] dm_rdata = '0;

  lsu_align #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wd(dm_wd), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_times[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] nxt_rdata = '0;
  int          nxt_lat = 0;
  logic [31:0] mem [128];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (dm_we) begin
      for (int i = 0; i < 4; i++)
        if (dm_be[i]) mem[dm_addr[8:2]][8*i +: 8] <= dm_wd[8*i +: 8];
    end
    if (dm_re) dm_rdata <= mem[dm_addr[8:2]];
  end

  // Every accepted request queues its expected response.
  always @(posedge clk) begin
    if (!reset && req_valid && req_ready) begin
      exp_q.push_back('{nxt_rdata, nxt_lat, cyc});
      acc_times.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got rdata %h expected no response", resp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input int lat);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got req_ready 0 expected 1");
    end
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    nxt_rdata = er; nxt_lat = lat;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic hold_run(input logic [8:0] a, input logic [31:0] er, input int lat, input int gap);
    int n;
    n = 0;
    acc_times.delete();
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = a; req_wdata = '0;
    nxt_rdata = er; nxt_lat = lat;
    req_valid = 1'b1;
    while (acc_times.size() < 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    if (acc_times.size() < 4) begin
      tests++;
      fails++;
      $display("FAIL hold_timeout: got %0d accepts expected 4", acc_times.size());
    end else begin
      chk("hold_spacing", 32'(acc_times[3] - acc_times[0]), 32'(3 * gap));
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_dm_strobes", {30'b0, dm_re, dm_we}, 32'd0);
    chk("rst_dm_addr", {23'b0, dm_addr}, 32'd0);
    chk("rst_dm_be_wd", dm_wd | {28'b0, dm_be}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b1, 3'b010, 9'h010, 32'h11223344, 32'h0, 2);
    chk("sw_acc0_be", {28'b0, dm_be}, 32'hF);
    chk("sw_acc0_addr", {23'b0, dm_addr}, 32'h010);
    chk("sw_acc0_wd", dm_wd, 32'h11223344);
    chk("acc0_ready_low", {31'b0, req_ready}, 32'd0);
    drain();
    issue(1'b0, 3'b010, 9'h010, 32'h0, 32'h11223344, 2);
    chk("lw_acc0_re", {30'b0, dm_re, dm_we}, 32'd2);
    chk("lw_acc0_be", {28'b0, dm_be}, 32'h0);
    drain();

    issue(1'b1, 3'b010, 9'h00C, 32'h80123456, 32'h0, 2);
    drain();
    issue(1'b0, 3'b000, 9'h00F, 32'h0, 32'hFFFFFF80, 2);
    chk("lb_acc0_addr", {23'b0, dm_addr}, 32'h00C);
    drain();
    issue(1'b0, 3'b100, 9'h00F, 32'h0, 32'h00000080, 2);
    drain();

    issue(1'b1, 3'b010, 9'h006, 32'hAABBCCDD, 32'h0, 3);
    chk("split_acc0_addr", {23'b0, dm_addr}, 32'h004);
    chk("split_acc0_be", {28'b0, dm_be}, 32'hC);
    chk("split_acc0_wd", dm_wd, 32'hCCDD0000);
    @(negedge clk);
    chk("split_acc1_addr", {23'b0, dm_addr}, 32'h008);
    chk("split_acc1_be", {28'b0, dm_be}, 32'h3);
    chk("split_acc1_wd", dm_wd, 32'h0000AABB);
    drain();
    issue(1'b0, 3'b010, 9'h006, 32'h0, 32'hAABBCCDD, 3);
    drain();
    issue(1'b0, 3'b001, 9'h007, 32'h0, 32'hFFFFBBCC, 3);
    drain();

    issue(1'b1, 3'b010, 9'h1FC, 32'hF0000000, 32'h0, 2);
    drain();
    issue(1'b1, 3'b000, 9'h000, 32'h00000012, 32'h0, 2);
    chk("sb_acc0_be", {28'b0, dm_be}, 32'h1);
    chk("sb_acc0_wd", dm_wd, 32'h00000012);
    drain();
    issue(1'b0, 3'b001, 9'h1FF, 32'h0, 32'h000012F0, 3);
    chk("wrap_acc0_addr", {23'b0, dm_addr}, 32'h1FC);
    @(negedge clk);
    chk("wrap_acc1_addr", {23'b0, dm_addr}, 32'h000);
    drain();
    issue(1'b1, 3'b000, 9'h000, 32'h00000080, 32'h0, 2);
    drain();
    issue(1'b0, 3'b101, 9'h1FF, 32'h0, 32'h000080F0, 3);
    drain();
    issue(1'b0, 3'b001, 9'h1FF, 32'h0, 32'hFFFF80F0, 3);
    drain();

    issue(1'b1, 3'b010, 9'h02A, 32'h55667788, 32'h0, 3);
    @(negedge clk);
    chk("abort_acc1_we", {31'b0, dm_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_we_drop", {31'b0, dm_we}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(1'b0, 3'b010, 9'h028, 32'h0, 32'h77880000, 2);
    drain();
    issue(1'b0, 3'b010, 9'h02C, 32'h0, 32'h00000000, 2);
    drain();

    hold_run(9'h010, 32'h11223344, 2, 3);
    hold_run(9'h006, 32'hAABBCCDD, 3, 4);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
